// File: rtl/mac_pipe.sv
// Four-stage signed multiply-accumulate pipeline: pre-adder, multiplier, post-adder.
// The post-add result can saturate or wrap, and it can be chained to a neighbour through PCOUT/PCIN.
module mac_pipe #(
   parameter int A_W = 27,
   parameter int B_W = 18,
   parameter int P_W = 48,
   parameter bit SAT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  in_valid,
   input  logic [2:0]            mode,
   input  logic                  acc_clr,
   input  logic signed [A_W-1:0] A,
   input  logic signed [A_W-1:0] D,
   input  logic signed [B_W-1:0] B,
   input  logic signed [P_W-1:0] C,
   input  logic signed [P_W-1:0] PCIN,
   output logic signed [P_W-1:0] P,
   output logic                  out_valid,
   output logic                  ovf,
   output logic signed [P_W-1:0] PCOUT,
   output logic signed [A_W-1:0] ACOUT,
   output logic signed [B_W-1:0] BCOUT
);

   localparam int PA_W = A_W + 1;
   localparam int M_W  = A_W + B_W + 1;
   localparam int S_W  = P_W + 2;

   logic signed [A_W-1:0]  a1_r, d1_r;
   logic signed [B_W-1:0]  b1_r, b2_r;
   logic signed [P_W-1:0]  c1_r, c2_r, c3_r;
   logic [2:0]             mode1_r, mode2_r, mode3_r;
   logic                   clr1_r, clr2_r, clr3_r;
   logic                   v1_r, v2_r, v3_r;
   logic signed [PA_W-1:0] pa_s, pa2_r;
   logic signed [M_W-1:0]  m_s, m3_r;
   logic signed [P_W-1:0]  addend_s, p_r;
   logic [S_W-1:0]         sum_s;
   logic [P_W:0]           fit_s;
   logic                   ovf_r, out_valid_r;

   // Returns {out_of_range, value}; out-of-range sums clamp when sat_en is set, else wrap.
   function automatic logic [P_W:0] post_fit(input logic [S_W-1:0] s, input logic sat_en);
      logic           over;
      logic [P_W-1:0] v;
      over = (s[S_W-1:P_W-1] != {3{s[P_W-1]}});
      if (over && sat_en) begin
         v = s[S_W-1] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
      end else begin
         v = s[P_W-1:0];
      end
      return {over, v};
   endfunction

   // Stage 1: capture operands, mode and valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         a1_r    <= {A_W{1'b0}};
         d1_r    <= {A_W{1'b0}};
         b1_r    <= {B_W{1'b0}};
         c1_r    <= {P_W{1'b0}};
         mode1_r <= 3'b000;
         clr1_r  <= 1'b0;
         v1_r    <= 1'b0;
      end else if (enable) begin
         a1_r    <= A;
         d1_r    <= D;
         b1_r    <= B;
         c1_r    <= C;
         mode1_r <= mode;
         clr1_r  <= acc_clr;
         v1_r    <= in_valid;
      end
   end

   // Pre-adder select; reserved modes behave as A+D.
   always_comb begin
      pa_s = {PA_W{1'b0}};
      case (mode1_r)
         3'b011:  pa_s = $signed({d1_r[A_W-1], d1_r}) - $signed({a1_r[A_W-1], a1_r});
         3'b100:  pa_s = $signed({a1_r[A_W-1], a1_r});
         default: pa_s = $signed({a1_r[A_W-1], a1_r}) + $signed({d1_r[A_W-1], d1_r});
      endcase
   end

   // Stage 2: register the pre-adder result with its side-band.
   always_ff @(posedge clk) begin
      if (rst) begin
         pa2_r   <= {PA_W{1'b0}};
         b2_r    <= {B_W{1'b0}};
         c2_r    <= {P_W{1'b0}};
         mode2_r <= 3'b000;
         clr2_r  <= 1'b0;
         v2_r    <= 1'b0;
      end else if (enable) begin
         pa2_r   <= pa_s;
         b2_r    <= b1_r;
         c2_r    <= c1_r;
         mode2_r <= mode1_r;
         clr2_r  <= clr1_r;
         v2_r    <= v1_r;
      end
   end

   // The full product fits in M_W bits, so a multiply truncated to M_W bits is exact.
   assign m_s = $signed({{B_W{pa2_r[PA_W-1]}}, pa2_r}) * $signed({{PA_W{b2_r[B_W-1]}}, b2_r});

   // Stage 3: register the full-width product.
   always_ff @(posedge clk) begin
      if (rst) begin
         m3_r    <= {M_W{1'b0}};
         c3_r    <= {P_W{1'b0}};
         mode3_r <= 3'b000;
         clr3_r  <= 1'b0;
         v3_r    <= 1'b0;
      end else if (enable) begin
         m3_r    <= m_s;
         c3_r    <= c2_r;
         mode3_r <= mode2_r;
         clr3_r  <= clr2_r;
         v3_r    <= v2_r;
      end
   end

   // Post-adder operand: P itself is the accumulator, and PCIN is taken live.
   always_comb begin
      addend_s = {P_W{1'b0}};
      case (mode3_r)
         3'b001:  addend_s = PCIN;
         3'b010:  addend_s = clr3_r ? {P_W{1'b0}} : p_r;
         default: addend_s = c3_r;
      endcase
   end

   assign sum_s = {{(S_W-M_W){m3_r[M_W-1]}}, m3_r} + {{2{addend_s[P_W-1]}}, addend_s};
   assign fit_s = post_fit(sum_s, SAT);

   // Stage 4: result register; only valid beats overwrite P and ovf.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_r         <= {P_W{1'b0}};
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else if (enable) begin
         out_valid_r <= v3_r;
         if (v3_r) begin
            p_r   <= fit_s[P_W-1:0];
            ovf_r <= fit_s[P_W];
         end
      end
   end

   assign P         = p_r;
   assign PCOUT     = p_r;
   assign ovf       = ovf_r;
   assign out_valid = out_valid_r;
   assign ACOUT     = a1_r;
   assign BCOUT     = b1_r;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: a saturating instance, a wrapping twin, and a cascaded neighbour.
module tb_mac_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, enable, in_valid, acc_clr;
   logic [2:0] mode;
   logic signed [26:0] a_in, d_in;
   logic signed [17:0] b_in;
   logic signed [47:0] c_in, pcin;
   logic signed [47:0] p, pcout, p_w, pcout_w;
   logic out_valid, ovf, ov_w, ovf_w;
   logic signed [26:0] acout, acout_w;
   logic signed [17:0] bcout, bcout_w;

   logic in_valid2, acc_clr2;
   logic [2:0] mode2;
   logic signed [26:0] a2, d2;
   logic signed [17:0] b2;
   logic signed [47:0] c2, p2, pcout2;
   logic ov2, ovf2;
   logic signed [26:0] acout2;
   logic signed [17:0] bcout2;

   int errors = 0;
   int checks = 0;

   localparam logic signed [47:0] PMAX = 48'sh7FFF_FFFF_FFFF;
   localparam logic signed [47:0] PMIN = 48'sh8000_0000_0000;

   mac_pipe #(.SAT(1'b1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
      .A(a_in), .D(d_in), .B(b_in), .C(c_in), .PCIN(pcin),
      .P(p), .out_valid(out_valid), .ovf(ovf), .PCOUT(pcout), .ACOUT(acout), .BCOUT(bcout));

   mac_pipe #(.SAT(1'b0)) dut_w (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .mode(mode), .acc_clr(acc_clr),
      .A(a_in), .D(d_in), .B(b_in), .C(c_in), .PCIN(pcin),
      .P(p_w), .out_valid(ov_w), .ovf(ovf_w), .PCOUT(pcout_w), .ACOUT(acout_w), .BCOUT(bcout_w));

   mac_pipe #(.SAT(1'b1)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid2), .mode(mode2), .acc_clr(acc_clr2),
      .A(a2), .D(d2), .B(b2), .C(c2), .PCIN(pcout),
      .P(p2), .out_valid(ov2), .ovf(ovf2), .PCOUT(pcout2), .ACOUT(acout2), .BCOUT(bcout2));

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic signed [26:0] a, input logic signed [26:0] d,
                        input logic signed [17:0] b, input logic signed [47:0] c,
                        input logic [2:0] m, input logic clr);
      in_valid = 1'b1; a_in = a; d_in = d; b_in = b; c_in = c; mode = m; acc_clr = clr;
   endtask

   task automatic test_reset();
      enable = 1'b0; rst = 1'b1; in_valid = 1'b0;
      step(); step();
      rst = 1'b0; enable = 1'b1;
      checks++; if (p !== 48'sd0) begin errors++; $display("FAIL rst_p got=%0d exp=0", p); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
      checks++; if (pcout !== 48'sd0) begin errors++; $display("FAIL rst_pcout got=%0d exp=0", pcout); end
      checks++; if (acout !== 27'sd0 || bcout !== 18'sd0) begin
         errors++; $display("FAIL rst_cout got=%0d/%0d exp=0/0", acout, bcout); end
   endtask

   task automatic test_mode000();
      drive(27'sd2, 27'sd5, 18'sd3, 48'sd4, 3'b000, 1'b0); step(); in_valid = 1'b0;
      checks++; if (acout !== 27'sd2 || bcout !== 18'sd3) begin
         errors++; $display("FAIL m000_cout got=%0d/%0d exp=2/3", acout, bcout); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL m000_early got=%b exp=0 at %0d", out_valid, i); end
      end
      step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd25 || ovf !== 1'b0) begin
         errors++; $display("FAIL m000_result got v=%b p=%0d ovf=%b exp v=1 p=25 ovf=0", out_valid, p, ovf); end
      checks++; if (pcout !== 48'sd25) begin errors++; $display("FAIL m000_pcout got=%0d exp=25", pcout); end
      step();
      checks++; if (out_valid !== 1'b0 || p !== 48'sd25) begin
         errors++; $display("FAIL m000_hold got v=%b p=%0d exp v=0 p=25", out_valid, p); end
   endtask

   task automatic test_back_to_back();
      logic signed [26:0] va [4] = '{27'sd3, 27'sd4, 27'sd1, 27'sd1};
      logic signed [26:0] vd [4] = '{27'sd10, 27'sd100, 27'sd2, 27'sd1};
      logic signed [17:0] vb [4] = '{-18'sd2, 18'sd5, 18'sd3, 18'sd2};
      logic signed [47:0] vc [4] = '{48'sd5, 48'sd1, 48'sd4, 48'sd7};
      logic [2:0]         vm [4] = '{3'b011, 3'b100, 3'b111, 3'b001};
      logic signed [47:0] ve [4] = '{-48'sd9, 48'sd21, 48'sd13, 48'sd14};
      pcin = 48'sd10;
      for (int i = 0; i < 4; i++) begin
         drive(va[i], vd[i], vb[i], vc[i], vm[i], 1'b0); step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b1 || p !== ve[i] || ovf !== 1'b0) begin
            errors++; $display("FAIL b2b_%0d got v=%b p=%0d ovf=%b exp v=1 p=%0d ovf=0", i, out_valid, p, ovf, ve[i]); end
         step();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
      pcin = 48'sd0;
   endtask

   task automatic test_accumulate();
      drive(27'sd1, 27'sd1, 18'sd2, 48'sd1000, 3'b010, 1'b1); step();
      drive(27'sd1, 27'sd0, 18'sd3, 48'sd1000, 3'b010, 1'b0); step();
      in_valid = 1'b0; step();
      drive(27'sd0, 27'sd2, -18'sd1, 48'sd1000, 3'b010, 1'b0); step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || p !== 48'sd4) begin errors++; $display("FAIL acc_0 got v=%b p=%0d exp v=1 p=4", out_valid, p); end
      step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd7) begin errors++; $display("FAIL acc_1 got v=%b p=%0d exp v=1 p=7", out_valid, p); end
      step();
      checks++; if (out_valid !== 1'b0 || p !== 48'sd7) begin errors++; $display("FAIL acc_bubble got v=%b p=%0d exp v=0 p=7", out_valid, p); end
      step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd5) begin errors++; $display("FAIL acc_2 got v=%b p=%0d exp v=1 p=5", out_valid, p); end
      step();
   endtask

   task automatic test_saturate();
      drive(27'sd1, 27'sd0, 18'sd1, PMAX, 3'b000, 1'b0); step(); in_valid = 1'b0;
      step(); step(); step();
      checks++; if (p !== PMAX || ovf !== 1'b1) begin errors++; $display("FAIL sat_pos got p=%0d ovf=%b exp p=%0d ovf=1", p, ovf, PMAX); end
      checks++; if (p_w !== PMIN || ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_pos got p=%0d ovf=%b exp p=%0d ovf=1", p_w, ovf_w, PMIN); end
      drive(27'sd1, 27'sd0, -18'sd1, 48'sd0, 3'b010, 1'b0); step(); in_valid = 1'b0;
      step(); step(); step();
      checks++; if (p !== PMAX - 48'sd1 || ovf !== 1'b0) begin errors++; $display("FAIL sat_acc got p=%0d ovf=%b exp p=%0d ovf=0", p, ovf, PMAX - 48'sd1); end
      checks++; if (p_w !== PMAX || ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_acc got p=%0d ovf=%b exp p=%0d ovf=1", p_w, ovf_w, PMAX); end
      drive(27'sd0, -27'sd1, 18'sd1, PMIN, 3'b000, 1'b0); step(); in_valid = 1'b0;
      step(); step(); step();
      checks++; if (p !== PMIN || ovf !== 1'b1) begin errors++; $display("FAIL sat_neg got p=%0d ovf=%b exp p=%0d ovf=1", p, ovf, PMIN); end
      checks++; if (p_w !== PMAX || ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_neg got p=%0d ovf=%b exp p=%0d ovf=1", p_w, ovf_w, PMAX); end
   endtask

   task automatic test_chain();
      pcin = 48'sd0;
      drive(27'sd1, 27'sd1, 18'sd1, 48'sd0, 3'b001, 1'b0); step(); in_valid = 1'b0;
      in_valid2 = 1'b1; a2 = 27'sd1; d2 = 27'sd1; b2 = 18'sd1; c2 = 48'sd0; mode2 = 3'b001; acc_clr2 = 1'b0;
      step(); in_valid2 = 1'b0;
      step(); step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd2) begin errors++; $display("FAIL chain_first got v=%b p=%0d exp v=1 p=2", out_valid, p); end
      step();
      checks++; if (ov2 !== 1'b1 || p2 !== 48'sd4) begin errors++; $display("FAIL chain_second got v=%b p=%0d exp v=1 p=4", ov2, p2); end
   endtask

   task automatic test_stall();
      drive(27'sd1, 27'sd2, 18'sd3, 48'sd0, 3'b000, 1'b0); step();
      drive(27'sd2, 27'sd3, 18'sd2, 48'sd1, 3'b000, 1'b0); step();
      drive(27'sd0, 27'sd5, 18'sd5, 48'sd5, 3'b000, 1'b0); step();
      enable = 1'b0;
      drive(27'sd9, 27'sd9, 18'sd9, 48'sd9, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (out_valid !== 1'b0 || p !== 48'sd2 || acout !== 27'sd0) begin
            errors++; $display("FAIL stall_freeze_%0d got v=%b p=%0d acout=%0d exp v=0 p=2 acout=0", i, out_valid, p, acout); end
      end
      enable = 1'b1;
      drive(27'sd7, -27'sd1, 18'sd2, -48'sd2, 3'b000, 1'b0); step(); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || p !== 48'sd9) begin errors++; $display("FAIL stall_0 got v=%b p=%0d exp v=1 p=9", out_valid, p); end
      step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd11) begin errors++; $display("FAIL stall_1 got v=%b p=%0d exp v=1 p=11", out_valid, p); end
      step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd30) begin errors++; $display("FAIL stall_2 got v=%b p=%0d exp v=1 p=30", out_valid, p); end
      step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd10) begin errors++; $display("FAIL stall_3 got v=%b p=%0d exp v=1 p=10", out_valid, p); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_tail got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_inflight();
      for (int i = 1; i <= 3; i++) begin
         drive(27'(i), 27'sd1, 18'sd1, 48'sd0, 3'b000, 1'b0); step();
      end
      in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
      checks++; if (p !== 48'sd0 || out_valid !== 1'b0 || pcout !== 48'sd0) begin
         errors++; $display("FAIL rstf_clear got p=%0d v=%b pcout=%0d exp 0/0/0", p, out_valid, pcout); end
      drive(27'sd2, 27'sd5, 18'sd3, 48'sd4, 3'b000, 1'b0); step(); in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (out_valid !== 1'b0 || p !== 48'sd0) begin
            errors++; $display("FAIL rstf_stale_%0d got v=%b p=%0d exp v=0 p=0", i, out_valid, p); end
      end
      step();
      checks++; if (out_valid !== 1'b1 || p !== 48'sd25) begin errors++; $display("FAIL rstf_next got v=%b p=%0d exp v=1 p=25", out_valid, p); end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; mode = 3'b000;
      a_in = 27'sd0; d_in = 27'sd0; b_in = 18'sd0; c_in = 48'sd0; pcin = 48'sd0;
      in_valid2 = 1'b0; acc_clr2 = 1'b0; mode2 = 3'b000;
      a2 = 27'sd0; d2 = 27'sd0; b2 = 18'sd0; c2 = 48'sd0;
      test_reset();
      test_mode000();
      test_back_to_back();
      test_accumulate();
      test_saturate();
      test_chain();
      test_stall();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
